// File: rtl/adpll_hop_pkg.sv
// Shared definitions for the ADPLL hop sequencer: state encoding, register map,
// reset defaults and CTRL/STATUS bit positions.
package adpll_hop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PD   = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_NEXT = 3'd4
  } state_t;

  localparam logic [4:0] ADDR_CTRL    = 5'd0;
  localparam logic [4:0] ADDR_STATUS  = 5'd1;
  localparam logic [4:0] ADDR_ALPHA   = 5'd2;
  localparam logic [4:0] ADDR_TIMEOUT = 5'd3;
  localparam logic [4:0] ADDR_SETTLE  = 5'd4;
  localparam logic [4:0] ADDR_NCH     = 5'd5;
  localparam logic [4:0] ADDR_CH0     = 5'd8;

  localparam logic [11:0] ALPHA_RST   = 12'h78E;
  localparam int          TIMEOUT_RST = 4096;
  localparam logic [7:0]  SETTLE_RST  = 8'd16;
  localparam logic [2:0]  NCH_RST     = 3'd1;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_IRQEN = 3;

  localparam int STAT_BUSY  = 3;
  localparam int STAT_DONE  = 4;
  localparam int STAT_TMO   = 5;
  localparam int STAT_QLOCK = 6;
  localparam int STAT_IDX   = 8;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_RX  = 2'd2;

endpackage

// File: rtl/adpll_hop_seq_if.sv
// CPU register-access bus of the ADPLL hop sequencer.
interface adpll_hop_seq_if;
  logic        select;
  logic        write;
  logic [4:0]  adress;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output select, write, adress, data_in, input data_out);
  modport slave  (input select, write, adress, data_in, output data_out);
endinterface

// File: rtl/adpll_hop_regs.sv
// CPU register bank: configuration registers, channel FCW table, read mux and
// the start/abort/status-clear strobes decoded from CPU writes.
module adpll_hop_regs
  import adpll_hop_pkg::*;
#(
  parameter int FCWW    = 26,
  parameter int NCH_MAX = 8,
  parameter int TOW     = 16,
  localparam int IDXW   = $clog2(NCH_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  adpll_hop_seq_if.slave   cpu,
  input  logic [31:0]      status,
  input  logic [IDXW-1:0]  idx,
  output logic             start,
  output logic             abort,
  output logic             status_wr,
  output logic             loop_en,
  output logic             irq_en,
  output logic [11:0]      alpha_cfg,
  output logic [TOW-1:0]   timeout_cfg,
  output logic [7:0]       settle_cfg,
  output logic [IDXW-1:0]  nch_last,
  output logic [FCWW-1:0]  cur_fcw
);

  logic [2:0]      nch_reg;
  logic [FCWW-1:0] ch_fcw [NCH_MAX];
  logic [31:0]     rd_data;
  logic            wr_en;
  logic            ch_hit;
  logic [IDXW-1:0] ch_sel;
  logic            unused_ok;

  assign wr_en     = cpu.select & cpu.write;
  assign ch_hit    = (cpu.adress[4:3] == 2'b01);
  assign ch_sel    = cpu.adress[IDXW-1:0];
  assign start     = wr_en & (cpu.adress == ADDR_CTRL) & cpu.data_in[CTRL_START];
  assign abort     = wr_en & (cpu.adress == ADDR_CTRL) & cpu.data_in[CTRL_ABORT];
  assign status_wr = wr_en & (cpu.adress == ADDR_STATUS);
  // NCH=0 encodes a full table: 0-1 wraps to the last index
  assign nch_last  = IDXW'(nch_reg - 3'd1);
  assign cur_fcw   = ch_fcw[idx];
  assign unused_ok = &{1'b0, cpu.data_in[31:FCWW]};

  // Configuration registers and channel table, written on select&write
  always_ff @(posedge clk) begin
    if (!rst) begin
      loop_en     <= 1'b0;
      irq_en      <= 1'b0;
      alpha_cfg   <= ALPHA_RST;
      timeout_cfg <= TOW'(TIMEOUT_RST);
      settle_cfg  <= SETTLE_RST;
      nch_reg     <= NCH_RST;
      for (int i = 0; i < NCH_MAX; i++) ch_fcw[i] <= '0;
    end else if (wr_en) begin
      if (ch_hit) begin
        ch_fcw[ch_sel] <= cpu.data_in[FCWW-1:0];
      end else begin
        case (cpu.adress)
          ADDR_CTRL: begin
            loop_en <= cpu.data_in[CTRL_LOOP];
            irq_en  <= cpu.data_in[CTRL_IRQEN];
          end
          ADDR_ALPHA:   alpha_cfg   <= cpu.data_in[11:0];
          ADDR_TIMEOUT: timeout_cfg <= cpu.data_in[TOW-1:0];
          ADDR_SETTLE:  settle_cfg  <= cpu.data_in[7:0];
          ADDR_NCH:     nch_reg     <= cpu.data_in[2:0];
          default: ;
        endcase
      end
    end
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_data = '0;
    case (cpu.adress)
      ADDR_CTRL: begin
        rd_data[CTRL_LOOP]  = loop_en;
        rd_data[CTRL_IRQEN] = irq_en;
      end
      ADDR_STATUS:  rd_data            = status;
      ADDR_ALPHA:   rd_data[11:0]      = alpha_cfg;
      ADDR_TIMEOUT: rd_data[TOW-1:0]   = timeout_cfg;
      ADDR_SETTLE:  rd_data[7:0]       = settle_cfg;
      ADDR_NCH:     rd_data[2:0]       = nch_reg;
      default: if (ch_hit) rd_data[FCWW-1:0] = ch_fcw[ch_sel];
    endcase
  end

  // Registered read data, updated only on a read access
  always_ff @(posedge clk) begin
    if (!rst) cpu.data_out <= '0;
    else if (cpu.select && !cpu.write) cpu.data_out <= rd_data;
  end

endmodule

// File: rtl/adpll_hop_seq.sv
// ADPLL hop sequencer: walks the channel table (power down, load FCW, RX until
// qualified lock or timeout, advance) and reports progress via STATUS and irq.
module adpll_hop_seq
  import adpll_hop_pkg::*;
#(
  parameter int FCWW      = 26,
  parameter int NCH_MAX   = 8,
  parameter int TOW       = 16,
  parameter int LOCK_QUAL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  adpll_hop_seq_if.slave   cpu,
  input  logic             adpll_locked,
  output logic [FCWW-1:0]  fcw,
  output logic [1:0]       adpll_mode,
  output logic [3:0]       alpha_l,
  output logic [3:0]       alpha_m,
  output logic [3:0]       alpha_s,
  output logic             irq
);

  localparam int IDXW = $clog2(NCH_MAX);
  localparam int LQW  = $clog2(LOCK_QUAL + 1);
  localparam logic [LQW-1:0] LQ_TGT = LQW'(LOCK_QUAL);

  state_t          state, state_n;
  logic [IDXW-1:0] idx, idx_n, nch_last;
  logic [7:0]      settle_cnt, settle_n, settle_cfg;
  logic [TOW-1:0]  cyc_cnt, cyc_n, timeout_cfg;
  logic [LQW-1:0]  lock_cnt, lock_n, lock_now;
  logic [1:0]      mode_n;
  logic            done, done_n, timeout, timeout_n, qlock, qlock_n, load;
  logic            start, abort, status_wr, loop_en, irq_en;
  logic [11:0]     alpha_cfg;
  logic [FCWW-1:0] cur_fcw;
  logic [31:0]     status;

  adpll_hop_regs #(.FCWW(FCWW), .NCH_MAX(NCH_MAX), .TOW(TOW)) u_regs (
    .clk(clk), .rst(rst), .cpu(cpu), .status(status), .idx(idx),
    .start(start), .abort(abort), .status_wr(status_wr),
    .loop_en(loop_en), .irq_en(irq_en), .alpha_cfg(alpha_cfg),
    .timeout_cfg(timeout_cfg), .settle_cfg(settle_cfg),
    .nch_last(nch_last), .cur_fcw(cur_fcw)
  );

  assign irq = irq_en & (done | timeout);

  // STATUS word assembly
  always_comb begin
    status              = '0;
    status[2:0]         = state;
    status[STAT_BUSY]   = (state != ST_IDLE);
    status[STAT_DONE]   = done;
    status[STAT_TMO]    = timeout;
    status[STAT_QLOCK]  = qlock;
    status[STAT_IDX +: IDXW] = idx;
  end

  // Next-state and next-value logic; en=0 freezes everything but drops lock history
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    settle_n  = settle_cnt;
    cyc_n     = cyc_cnt;
    lock_n    = lock_cnt;
    mode_n    = adpll_mode;
    done_n    = done;
    timeout_n = timeout;
    qlock_n   = qlock;
    load      = 1'b0;
    lock_now  = adpll_locked ? lock_cnt + LQW'(1) : '0;
    if (status_wr) begin
      done_n    = 1'b0;
      timeout_n = 1'b0;
    end
    if (!en) begin
      lock_n = '0;
    end else if (abort) begin
      state_n = ST_IDLE;
      mode_n  = MODE_OFF;
      lock_n  = '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state_n   = ST_PD;
          idx_n     = '0;
          settle_n  = 8'd1;
          mode_n    = MODE_OFF;
          done_n    = 1'b0;
          timeout_n = 1'b0;
          qlock_n   = 1'b0;
        end
        ST_PD: begin
          if (settle_cnt >= settle_cfg) state_n = ST_LOAD;
          else settle_n = settle_cnt + 8'd1;
        end
        ST_LOAD: begin
          load    = 1'b1;
          state_n = ST_RUN;
          mode_n  = MODE_RX;
          cyc_n   = TOW'(1);
          lock_n  = '0;
        end
        ST_RUN: begin
          // lock qualification takes priority over a coincident timeout
          if (lock_now == LQ_TGT) begin
            state_n = ST_NEXT;
            qlock_n = 1'b1;
          end else if (cyc_cnt >= timeout_cfg) begin
            state_n   = ST_IDLE;
            mode_n    = MODE_OFF;
            timeout_n = 1'b1;
            lock_n    = '0;
          end else begin
            cyc_n  = cyc_cnt + TOW'(1);
            lock_n = lock_now;
          end
        end
        ST_NEXT: begin
          lock_n = '0;
          if (idx < nch_last || loop_en) begin
            idx_n    = (idx < nch_last) ? idx + IDXW'(1) : '0;
            state_n  = ST_PD;
            settle_n = 8'd1;
            mode_n   = MODE_OFF;
            qlock_n  = 1'b0;
          end else begin
            // RX mode is left on after completion
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else state <= state_n;
  end

  // Counters, sticky flags and ADPLL-facing outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      cyc_cnt    <= '0;
      lock_cnt   <= '0;
      adpll_mode <= MODE_OFF;
      done       <= 1'b0;
      timeout    <= 1'b0;
      qlock      <= 1'b0;
      fcw        <= '0;
      alpha_l    <= ALPHA_RST[3:0];
      alpha_m    <= ALPHA_RST[7:4];
      alpha_s    <= ALPHA_RST[11:8];
    end else begin
      idx        <= idx_n;
      settle_cnt <= settle_n;
      cyc_cnt    <= cyc_n;
      lock_cnt   <= lock_n;
      adpll_mode <= mode_n;
      done       <= done_n;
      timeout    <= timeout_n;
      qlock      <= qlock_n;
      if (load) begin
        fcw     <= cur_fcw;
        alpha_l <= alpha_cfg[3:0];
        alpha_m <= alpha_cfg[7:4];
        alpha_s <= alpha_cfg[11:8];
      end
    end
  end

endmodule

// File: tb/tb_adpll_hop_seq.sv
// Directed bench for the ADPLL hop sequencer.
module tb_adpll_hop_seq;
  import adpll_hop_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        adpll_locked;
  logic [25:0] fcw;
  logic [1:0]  adpll_mode;
  logic [3:0]  alpha_l, alpha_m, alpha_s;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] chv [3];
  logic [7:0]  pat;

  adpll_hop_seq_if cpu();

  adpll_hop_seq dut (
    .clk(clk), .rst(rst), .en(en), .cpu(cpu), .adpll_locked(adpll_locked),
    .fcw(fcw), .adpll_mode(adpll_mode), .alpha_l(alpha_l), .alpha_m(alpha_m),
    .alpha_s(alpha_s), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cpu.select = 1'b1; cpu.write = 1'b1; cpu.adress = a; cpu.data_in = d;
    tick();
    cpu.select = 1'b0; cpu.write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    cpu.select = 1'b1; cpu.write = 1'b0; cpu.adress = a;
    tick();
    cpu.select = 1'b0;
    chk(tag, cpu.data_out, exp);
  endtask

  initial begin
    cpu.select = 1'b0; cpu.write = 1'b0; cpu.adress = '0; cpu.data_in = '0;
    rst = 1'b0; en = 1'b1; adpll_locked = 1'b0;
    chv[0] = 32'h0A00000; chv[1] = 32'h0A04000; chv[2] = 32'h0A08000;
    pat = 8'b1111_0111;

    // reset values
    tick(); tick();
    chk("rst_fcw", 32'(fcw), 32'h0);
    chk("rst_mode", 32'(adpll_mode), 32'h0);
    chk("rst_alpha", 32'({alpha_s, alpha_m, alpha_l}), 32'h78E);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_dout", cpu.data_out, 32'h0);
    rst = 1'b1;
    rd(ADDR_ALPHA, 32'h78E, "rd_alpha");
    rd(ADDR_TIMEOUT, 32'd4096, "rd_timeout");
    rd(ADDR_SETTLE, 32'd16, "rd_settle");
    rd(ADDR_NCH, 32'd1, "rd_nch");
    rd(ADDR_STATUS, 32'h0, "rd_status_rst");
    wr(5'd6, 32'hFFFF);
    rd(5'd6, 32'h0, "rd_unmapped6");
    rd(5'd20, 32'h0, "rd_unmapped20");

    // two-channel run with lock held high
    wr(ADDR_NCH, 32'd2);
    wr(5'd8, chv[0]);
    wr(5'd9, chv[1]);
    wr(ADDR_SETTLE, 32'd3);
    rd(5'd9, chv[1], "rd_ch1");
    adpll_locked = 1'b1;
    wr(ADDR_CTRL, 32'h9);
    chk("pd_mode", 32'(adpll_mode), 32'h0);
    repeat (3) tick();
    chk("pd3_fcw", 32'(fcw), 32'h0);
    chk("pd3_mode", 32'(adpll_mode), 32'h0);
    tick();
    chk("ch0_fcw", 32'(fcw), chv[0]);
    chk("ch0_mode", 32'(adpll_mode), 32'h2);
    chk("ch0_alpha", 32'({alpha_s, alpha_m, alpha_l}), 32'h78E);
    repeat (3) tick();
    chk("ch0_run3", 32'(adpll_mode), 32'h2);
    tick();
    chk("ch0_next", 32'(adpll_mode), 32'h2);
    tick();
    chk("ch1_pd", 32'(adpll_mode), 32'h0);
    repeat (3) tick();
    chk("ch1_load_fcw", 32'(fcw), chv[0]);
    tick();
    chk("ch1_fcw", 32'(fcw), chv[1]);
    repeat (4) tick();
    chk("ch1_next_irq", 32'(irq), 32'h0);
    tick();
    chk("done_irq", 32'(irq), 32'h1);
    chk("done_mode", 32'(adpll_mode), 32'h2);
    rd(ADDR_STATUS, 32'h150, "done_status");
    wr(ADDR_STATUS, 32'h0);
    chk("clr_irq", 32'(irq), 32'h0);
    rd(ADDR_STATUS, 32'h140, "clr_status");

    // timeout with lock low
    wr(ADDR_TIMEOUT, 32'd20);
    adpll_locked = 1'b0;
    wr(ADDR_CTRL, 32'h9);
    repeat (23) tick();
    chk("tmo_c20_mode", 32'(adpll_mode), 32'h2);
    chk("tmo_c20_irq", 32'(irq), 32'h0);
    tick();
    chk("tmo_mode", 32'(adpll_mode), 32'h0);
    chk("tmo_irq", 32'(irq), 32'h1);
    rd(ADDR_STATUS, 32'h20, "tmo_status");
    wr(ADDR_STATUS, 32'h0);
    chk("tmo_clr_irq", 32'(irq), 32'h0);

    // interrupted lock pattern: only the final 4-cycle run qualifies
    wr(ADDR_CTRL, 32'h9);
    repeat (4) tick();
    for (int k = 0; k < 8; k++) begin
      adpll_locked = pat[k];
      tick();
      chk("lockpat_run", 32'(adpll_mode), 32'h2);
    end
    tick();
    chk("lockpat_pd", 32'(adpll_mode), 32'h0);
    wr(ADDR_CTRL, 32'hA);
    rd(ADDR_STATUS, 32'h100, "lockpat_status");

    // lock qualification and timeout on the same edge
    wr(ADDR_NCH, 32'd1);
    wr(ADDR_TIMEOUT, 32'd4);
    adpll_locked = 1'b1;
    wr(ADDR_CTRL, 32'h9);
    repeat (8) tick();
    chk("tie_next_mode", 32'(adpll_mode), 32'h2);
    chk("tie_next_irq", 32'(irq), 32'h0);
    tick();
    chk("tie_done_irq", 32'(irq), 32'h1);
    rd(ADDR_STATUS, 32'h50, "tie_status");
    wr(ADDR_STATUS, 32'h0);

    // looping over three channels, then ALPHA write and abort mid-RUN
    wr(5'd10, chv[2]);
    wr(ADDR_NCH, 32'd3);
    wr(ADDR_SETTLE, 32'd0);
    wr(ADDR_TIMEOUT, 32'd100);
    wr(ADDR_CTRL, 32'hD);
    repeat (2) tick();
    chk("loop_fcw0", 32'(fcw), chv[0]);
    for (int j = 1; j < 5; j++) begin
      repeat (7) tick();
      chk("loop_fcw", 32'(fcw), chv[j % 3]);
    end
    wr(ADDR_ALPHA, 32'h123);
    chk("alpha_hold_run", 32'({alpha_s, alpha_m, alpha_l}), 32'h78E);
    wr(ADDR_CTRL, 32'hE);
    chk("abort_mode", 32'(adpll_mode), 32'h0);
    chk("abort_alpha", 32'({alpha_s, alpha_m, alpha_l}), 32'h78E);
    rd(ADDR_STATUS, 32'h100, "abort_status");
    wr(ADDR_CTRL, 32'h9);
    tick();
    chk("alpha_at_load", 32'({alpha_s, alpha_m, alpha_l}), 32'h78E);
    tick();
    chk("alpha_after_load", 32'({alpha_s, alpha_m, alpha_l}), 32'h123);
    wr(ADDR_CTRL, 32'hA);

    // enable freeze mid-RUN delays the timeout by the frozen cycles
    wr(ADDR_NCH, 32'd1);
    wr(ADDR_TIMEOUT, 32'd20);
    adpll_locked = 1'b0;
    wr(ADDR_CTRL, 32'h9);
    repeat (6) tick();
    en = 1'b0;
    rd(ADDR_STATUS, 32'h0B, "freeze_status");
    repeat (9) tick();
    chk("freeze_mode", 32'(adpll_mode), 32'h2);
    en = 1'b1;
    repeat (15) tick();
    chk("thaw_c20_mode", 32'(adpll_mode), 32'h2);
    chk("thaw_c20_irq", 32'(irq), 32'h0);
    tick();
    chk("thaw_tmo_mode", 32'(adpll_mode), 32'h0);
    chk("thaw_tmo_irq", 32'(irq), 32'h1);
    wr(ADDR_CTRL, 32'h0);
    chk("mask_irq", 32'(irq), 32'h0);
    rd(ADDR_STATUS, 32'h20, "mask_sticky");
    wr(ADDR_CTRL, 32'h8);
    chk("unmask_irq", 32'(irq), 32'h1);

    // reset in the middle of PD
    wr(ADDR_SETTLE, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("mrst_fcw", 32'(fcw), 32'h0);
    chk("mrst_mode", 32'(adpll_mode), 32'h0);
    chk("mrst_alpha", 32'({alpha_s, alpha_m, alpha_l}), 32'h78E);
    chk("mrst_irq", 32'(irq), 32'h0);
    chk("mrst_dout", cpu.data_out, 32'h0);
    rst = 1'b1;
    rd(ADDR_ALPHA, 32'h78E, "mrst_rd_alpha");
    rd(ADDR_STATUS, 32'h0, "mrst_rd_status");
    rd(ADDR_CTRL, 32'h0, "mrst_rd_ctrl");
    rd(5'd8, 32'h0, "mrst_rd_ch0");
    rd(ADDR_TIMEOUT, 32'd4096, "mrst_rd_timeout");
    rd(ADDR_NCH, 32'd1, "mrst_rd_nch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
